score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Game-side producer of the score state that the on-screen pip display consumes.
//  Counts goals for both players and runs the rally/serve/game-over sequence.
//  Emits per-player thermometer pip masks, latched on frame boundaries so the
//  scanout never tears mid-frame.
//  Sits between ball/collision logic (goal strobes) and the video overlay (pip masks).
// PARAMETERS
//  MAX_POINTS   5    points to win; legal range 1..5 (display has 5 pips/player)
//  HOLD_FRAMES  60   frames the ball stays frozen after a point; must be >= 1
//  HOLD_W       6    width of hold frame counter; 2**HOLD_W >= HOLD_FRAMES
// PORTS
//  clk          in   1  system/pixel clock
//  rst          in   1  asynchronous, active-high reset
//  frame_tick   in   1  1-cycle strobe at start of vertical blank
//  start        in   1  debounced start/restart request, level or pulse
//  goal_p1      in   1  level: ball in P2's goal zone (point to P1)
//  goal_p2      in   1  level: ball in P1's goal zone (point to P2)
//  p1_score     out  3  P1 score, 0..MAX_POINTS
//  p2_score     out  3  P2 score, 0..MAX_POINTS
//  p1_pips      out  5  P1 thermometer mask, bit i set iff score > i
//  p2_pips      out  5  P2 thermometer mask
//  ball_freeze  out  1  high in every state except PLAY
//  ball_reset   out  1  1-cycle pulse: re-centre ball, launch serve
//  game_over    out  1  high in OVER
//  winner       out  1  0 = P1, 1 = P2; valid only while game_over=1
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, scores 0, pips 0, hold count 0,
//   ball_freeze 1, ball_reset 0, game_over 0, winner 0.
//   Goal edge-detect registers cleared to 0.
//  Goal edge detect: g_prev <= goal_x every cycle in all states.
//   A point = goal_x & ~g_prev, sampled only in PLAY.
//  FSM (registered, one transition per cycle):
//   IDLE: start=1 -> PLAY, with ball_reset pulse in that same transition cycle.
//   PLAY, exactly one goal edge:
//    - that player's score +1 on the next edge.
//    - if new score == MAX_POINTS -> OVER; winner = scorer.
//    - else -> HOLD; hold count cleared.
//   PLAY, both goal edges in the same cycle: no score change, -> HOLD (replay).
//   HOLD: on each frame_tick, count+1.
//    - on frame_tick with count == HOLD_FRAMES-1 -> PLAY; ball_reset pulses 1 cycle.
//    - HOLD lasts exactly HOLD_FRAMES frame_ticks.
//   OVER: game_over=1, scores frozen.
//    - start=1 -> scores cleared to 0 -> PLAY; ball_reset pulses.
//  Ignored inputs: start in PLAY/HOLD; goal edges outside PLAY (g_prev still tracks).
//  Scores saturate at MAX_POINTS and never wrap.
//  p1_score/p2_score update one cycle after the goal edge.
//  Pip masks: load ((1<<score)-1) only on frame_tick and hold otherwise.
//   Latency: a score change appears at the first frame_tick strictly after the
//   score register updates.
//   frame_tick coincident with the goal edge shows the old score.
//  Restart clear: on OVER -> PLAY, pips drop to 0 at the next frame_tick.
//  rst asserted mid-HOLD or mid-OVER: everything returns to reset values
//   immediately, with no ball_reset pulse.
// TESTING
//  1. Reset, start=1 one cycle -> ball_reset pulses once, ball_freeze=0, scores 0/0.
//  2. PLAY, goal_p1 held high 10 cycles -> p1_score=1 (single point),
//     ball_freeze=1, p1_pips=5'b00001 after next frame_tick.
//  3. HOLD_FRAMES=60: count ticks after goal -> ball_reset on the 60th tick,
//     not on the 59th; ball_freeze drops the same cycle.
//  4. goal_p1 and goal_p2 rising in the same cycle -> scores unchanged,
//     HOLD entered, replay serve after HOLD_FRAMES ticks.
//  5. Drive P2 to 5 goals -> game_over=1, winner=1, p2_pips=5'b11111.
//     Further goals: no change. start -> scores 0, ball_reset pulse,
//     pips 0 at next frame_tick.
//  6. Assert rst mid-HOLD with score 3/2 -> all outputs at reset values
//     asynchronously; start required to resume.

Source files
------------

// File: rtl/score_keeper.sv
// Goal counter and rally/serve/game-over sequencer for two players.
// Pip masks are latched on frame_tick so the overlay never tears mid-frame.
module score_keeper #(
  parameter int MAX_POINTS  = 5,
  parameter int HOLD_FRAMES = 60,
  parameter int HOLD_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [4:0] p1_pips,
  output logic [4:0] p2_pips,
  output logic       ball_freeze,
  output logic       ball_reset,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HOLD,
    OVER
  } state_t;

  localparam logic [2:0] MAX_S = 3'(MAX_POINTS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              g1_prev;
  logic              g2_prev;
  logic              e1;
  logic              e2;
  logic [2:0]        p1_next;
  logic [2:0]        p2_next;

  assign e1 = goal_p1 & ~g1_prev;
  assign e2 = goal_p2 & ~g2_prev;
  assign p1_next = p1_score + 3'd1;
  assign p2_next = p2_score + 3'd1;

  function automatic logic [4:0] pips_of(input logic [2:0] s);
    logic [5:0] m;
    m = (6'd1 << s) - 6'd1;
    return m[4:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      g1_prev     <= 1'b0;
      g2_prev     <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      p1_pips     <= '0;
      p2_pips     <= '0;
      ball_freeze <= 1'b1;
      ball_reset  <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      g1_prev    <= goal_p1;
      g2_prev    <= goal_p2;
      ball_reset <= 1'b0;
      // Masks sample the pre-update score register on this edge.
      if (frame_tick) begin
        p1_pips <= pips_of(p1_score);
        p2_pips <= pips_of(p2_score);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= PLAY;
            ball_reset  <= 1'b1;
            ball_freeze <= 1'b0;
          end
        end
        PLAY: begin
          if (e1 && e2) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            ball_freeze <= 1'b1;
          end else if (e1) begin
            ball_freeze <= 1'b1;
            if (p1_score < MAX_S) p1_score <= p1_next;
            if (p1_next == MAX_S) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else if (e2) begin
            ball_freeze <= 1'b1;
            if (p2_score < MAX_S) p2_score <= p2_next;
            if (p2_next == MAX_S) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= PLAY;
              hold_cnt    <= '0;
              ball_reset  <= 1'b1;
              ball_freeze <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        OVER: begin
          if (start) begin
            state       <= PLAY;
            p1_score    <= '0;
            p2_score    <= '0;
            game_over   <= 1'b0;
            ball_reset  <= 1'b1;
            ball_freeze <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expectations queued at stimulus time,
// popped and checked against DUT outputs after each step.
module tb_score_keeper;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       goal_p1;
  logic       goal_p2;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [4:0] p1_pips;
  logic [4:0] p2_pips;
  logic       ball_freeze;
  logic       ball_reset;
  logic       game_over;
  logic       winner;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic br_s;
  logic fz_s;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .goal_p1     (goal_p1),
    .goal_p2     (goal_p2),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .p1_pips     (p1_pips),
    .p2_pips     (p2_pips),
    .ball_freeze (ball_freeze),
    .ball_reset  (ball_reset),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_underflow: observed %0d, nothing expected", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    br_s = ball_reset;
    fz_s = ball_freeze;
    frame_tick = 1'b0;
    step();
  endtask

  task automatic point(input int who);
    if (who == 1) goal_p1 = 1'b1;
    else goal_p2 = 1'b1;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string p);
    push({p, "_freeze"}, 1);
    push({p, "_p1"}, 0);
    push({p, "_p2"}, 0);
    push({p, "_p1pips"}, 0);
    push({p, "_p2pips"}, 0);
    push({p, "_over"}, 0);
    push({p, "_breset"}, 0);
    push({p, "_winner"}, 0);
    pop_chk(32'(ball_freeze));
    pop_chk(32'(p1_score));
    pop_chk(32'(p2_score));
    pop_chk(32'(p1_pips));
    pop_chk(32'(p2_pips));
    pop_chk(32'(game_over));
    pop_chk(32'(ball_reset));
    pop_chk(32'(winner));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_tick = 1'b0;
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    br_s = 1'b0;
    fz_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    step();

    // Serve from IDLE
    start = 1'b1;
    push("t1_breset", 1);
    push("t1_freeze", 0);
    step();
    pop_chk(32'(ball_reset));
    pop_chk(32'(ball_freeze));
    start = 1'b0;
    push("t1_breset_once", 0);
    push("t1_p1", 0);
    push("t1_p2", 0);
    step();
    pop_chk(32'(ball_reset));
    pop_chk(32'(p1_score));
    pop_chk(32'(p2_score));

    // Held goal level counts once
    goal_p1 = 1'b1;
    push("t2_p1_next", 1);
    step();
    pop_chk(32'(p1_score));
    repeat (9) step();
    goal_p1 = 1'b0;
    push("t2_p1_held", 1);
    push("t2_freeze", 1);
    push("t2_pips_prefr", 0);
    pop_chk(32'(p1_score));
    pop_chk(32'(ball_freeze));
    pop_chk(32'(p1_pips));
    frame();
    push("t2_pips", 5'b00001);
    pop_chk(32'(p1_pips));

    // Hold lasts exactly 60 ticks (one already used above)
    repeat (58) frame();
    push("t3_br_tick59", 0);
    push("t3_fz_tick59", 1);
    pop_chk(32'(br_s));
    pop_chk(32'(fz_s));
    frame();
    push("t3_br_tick60", 1);
    push("t3_fz_tick60", 0);
    pop_chk(32'(br_s));
    pop_chk(32'(fz_s));

    // Simultaneous goals: replay
    goal_p1 = 1'b1;
    goal_p2 = 1'b1;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    push("t4_p1", 1);
    push("t4_p2", 0);
    push("t4_freeze", 1);
    pop_chk(32'(p1_score));
    pop_chk(32'(p2_score));
    pop_chk(32'(ball_freeze));
    step();
    repeat (59) frame();
    push("t4_br_tick59", 0);
    pop_chk(32'(br_s));
    frame();
    push("t4_br_tick60", 1);
    pop_chk(32'(br_s));

    // P2 wins
    for (int i = 1; i <= 5; i++) begin
      point(2);
      push("t5_p2_prog", 32'(i));
      pop_chk(32'(p2_score));
      if (i < 5) repeat (60) frame();
    end
    push("t5_over", 1);
    push("t5_winner", 1);
    push("t5_p1", 1);
    pop_chk(32'(game_over));
    pop_chk(32'(winner));
    pop_chk(32'(p1_score));
    frame();
    push("t5_p2pips", 5'b11111);
    push("t5_p1pips", 5'b00001);
    pop_chk(32'(p2_pips));
    pop_chk(32'(p1_pips));
    point(2);
    point(1);
    push("t5_p2_sat", 5);
    push("t5_p1_frozen", 1);
    pop_chk(32'(p2_score));
    pop_chk(32'(p1_score));
    start = 1'b1;
    step();
    start = 1'b0;
    push("t5_rs_p1", 0);
    push("t5_rs_p2", 0);
    push("t5_rs_breset", 1);
    push("t5_rs_over", 0);
    pop_chk(32'(p1_score));
    pop_chk(32'(p2_score));
    pop_chk(32'(ball_reset));
    pop_chk(32'(game_over));
    step();
    push("t5_pips_held", 5'b11111);
    pop_chk(32'(p2_pips));
    frame();
    push("t5_pips_clr", 0);
    pop_chk(32'(p2_pips));

    // Async reset mid-HOLD at 3/2
    point(1);
    repeat (60) frame();
    point(2);
    repeat (60) frame();
    point(1);
    repeat (60) frame();
    point(2);
    repeat (60) frame();
    point(1);
    repeat (5) frame();
    push("t6_p1", 3);
    push("t6_p2", 2);
    push("t6_freeze", 1);
    pop_chk(32'(p1_score));
    pop_chk(32'(p2_score));
    pop_chk(32'(ball_freeze));
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    step();
    rst = 1'b0;
    repeat (3) step();
    point(1);
    push("t6_idle_freeze", 1);
    push("t6_idle_p1", 0);
    pop_chk(32'(ball_freeze));
    pop_chk(32'(p1_score));
    start = 1'b1;
    step();
    start = 1'b0;
    push("t6_resume_br", 1);
    push("t6_resume_fz", 0);
    pop_chk(32'(ball_reset));
    pop_chk(32'(ball_freeze));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
